// File: rtl/dpram_drain_if.sv
// Outbound word stream from dpram_drain toward the downstream consumer.
// A word moves on a rising edge where tx_valid && tx_ready; once tx_valid is
// high, tx_data and tx_last stay stable until that edge, and tx_last is only
// meaningful while tx_valid is high.
interface dpram_drain_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/dpram_drain.sv
// Drains a block of 32-bit words from a DPRAM (1-cycle read latency) onto a
// valid/ready stream, one word per address/data/send round trip.
module dpram_drain #(
    parameter int P_DPRAM_ADR_WIDTH = 10,
    parameter int P_MAX_LEN         = 2**P_DPRAM_ADR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         dpram_run,
    input  logic [15:0]                  dpram_len,
    output logic                         dpram_busy,
    output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
    input  logic [31:0]                  dpram_rd_data,
    dpram_drain_if.master                tx,
    output logic                         err_len,
    input  logic                         err_clr,
    output logic [31:0]                  xfer_cnt,
    output logic [2:0]                   state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_SEND    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0]                  MAX_LEN   = 32'(P_MAX_LEN);
    localparam logic [P_DPRAM_ADR_WIDTH-1:0] ADDR_STEP = P_DPRAM_ADR_WIDTH'(1);

    state_t      state;
    logic [15:0] len;
    logic [15:0] index;

    logic run_req;
    logic len_ok;
    logic err_set;
    logic is_last_word;

    // A run is only considered while idle and enabled; runs elsewhere are ignored.
    assign run_req      = (state == S_IDLE) && en && dpram_run;
    assign len_ok       = (dpram_len != 16'd0) && ({16'd0, dpram_len} <= MAX_LEN);
    assign err_set      = run_req && !len_ok;
    assign is_last_word = (index == (len - 16'd1));
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            dpram_busy    <= 1'b0;
            dpram_rd_addr <= '0;
            tx.tx_data    <= '0;
            tx.tx_valid   <= 1'b0;
            tx.tx_last    <= 1'b0;
            err_len       <= 1'b0;
            xfer_cnt      <= '0;
            index         <= '0;
            len           <= '0;
        end else begin
            // Clear wins over a same-cycle illegal-length set.
            if (err_clr) begin
                err_len <= 1'b0;
            end else if (err_set) begin
                err_len <= 1'b1;
            end

            if (!en) begin
                state       <= S_IDLE;
                dpram_busy  <= 1'b0;
                tx.tx_valid <= 1'b0;
                tx.tx_last  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run_req && len_ok) begin
                            len           <= dpram_len;
                            index         <= '0;
                            dpram_rd_addr <= '0;
                            dpram_busy    <= 1'b1;
                            state         <= S_RD_ADDR;
                        end
                    end
                    S_RD_ADDR: begin
                        state <= S_RD_DATA;
                    end
                    S_RD_DATA: begin
                        tx.tx_data  <= dpram_rd_data;
                        tx.tx_valid <= 1'b1;
                        tx.tx_last  <= is_last_word;
                        state       <= S_SEND;
                    end
                    S_SEND: begin
                        if (tx.tx_ready) begin
                            tx.tx_valid <= 1'b0;
                            tx.tx_last  <= 1'b0;
                            if (tx.tx_last) begin
                                state <= S_DONE;
                            end else begin
                                index         <= index + 16'd1;
                                dpram_rd_addr <= dpram_rd_addr + ADDR_STEP;
                                state         <= S_RD_ADDR;
                            end
                        end
                    end
                    S_DONE: begin
                        dpram_busy <= 1'b0;
                        xfer_cnt   <= xfer_cnt + 32'd1;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dpram_drain.sv
// Directed bench for dpram_drain: behavioural DPRAM, stream monitor with an
// expected-word queue, and hand-computed checks on latency, errors and aborts.
module tb_dpram_drain;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        dpram_run;
    logic [15:0] dpram_len;
    logic        dpram_busy;
    logic [9:0]  dpram_rd_addr;
    logic [31:0] dpram_rd_data;
    logic        err_len;
    logic        err_clr;
    logic [31:0] xfer_cnt;
    logic [2:0]  state_dbg;

    dpram_drain_if bus ();

    dpram_drain #(
        .P_DPRAM_ADR_WIDTH(10),
        .P_MAX_LEN        (1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .dpram_run    (dpram_run),
        .dpram_len    (dpram_len),
        .dpram_busy   (dpram_busy),
        .dpram_rd_addr(dpram_rd_addr),
        .dpram_rd_data(dpram_rd_data),
        .tx           (bus),
        .err_len      (err_len),
        .err_clr      (err_clr),
        .xfer_cnt     (xfer_cnt),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DPRAM model (1-cycle read latency) ----------------
    logic [31:0] ram [1024];
    always @(posedge clk) dpram_rd_data <= ram[dpram_rd_addr];

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    logic [32:0] exp_word;
    int          checks;
    int          errors;
    int          beats;
    int          extra;
    int          busy_cycles;
    logic [9:0]  last_addr;
    logic        stall_prev;
    logic [31:0] held_data;
    logic        held_last;
    logic [31:0] exp_xfer;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (dpram_busy) busy_cycles++;
            if (bus.tx_last) check("last_has_valid", {31'd0, bus.tx_valid}, 32'd1);
            if (stall_prev) begin
                check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                check("hold_data", bus.tx_data, held_data);
                check("hold_last", {31'd0, bus.tx_last}, {31'd0, held_last});
            end
            stall_prev = bus.tx_valid && !bus.tx_ready && en;
            held_data  = bus.tx_data;
            held_last  = bus.tx_last;
            if (bus.tx_valid && bus.tx_ready && en) begin
                beats++;
                if (bus.tx_last) last_addr = dpram_rd_addr;
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    exp_word = exp_q.pop_front();
                    check("beat_data", bus.tx_data, exp_word[31:0]);
                    check("beat_last", {31'd0, bus.tx_last}, {31'd0, exp_word[32]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [15:0] len);
        @(posedge clk); #1;
        dpram_run = 1'b1;
        dpram_len = len;
        @(posedge clk); #1;
        dpram_run = 1'b0;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), ram[i]});
        end
        check("ram_base", ram[0], base);
    endtask

    task automatic wait_idle(input int budget, input bit rnd, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            if (!dpram_busy) break;
        end
        check(tag, {31'd0, dpram_busy}, 32'd0);
        bus.tx_ready = 1'b1;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0; errors = 0; beats = 0; extra = 0; busy_cycles = 0;
        stall_prev = 1'b0; held_data = '0; held_last = 1'b0; last_addr = '0;
        exp_xfer = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
        rst_n = 1'b0; en = 1'b1; dpram_run = 1'b0; dpram_len = 16'd0;
        err_clr = 1'b0; bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        check("rst_busy", {31'd0, dpram_busy}, 32'd0);
        check("rst_addr", {22'd0, dpram_rd_addr}, 32'd0);
        check("rst_data", bus.tx_data, 32'd0);
        check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_last", {31'd0, bus.tx_last}, 32'd0);
        check("rst_err", {31'd0, err_len}, 32'd0);
        check("rst_xfer", xfer_cnt, 32'd0);
        check("rst_state", {29'd0, state_dbg}, 32'd0);

        // single word: latency and busy width
        ram[0] = 32'hDEADBEEF;
        push_words(1, 32'hDEADBEEF);
        busy_cycles = 0;
        start_run(16'd1);
        check("lat_busy_n1", {31'd0, dpram_busy}, 32'd1);
        check("lat_valid_n1", {31'd0, bus.tx_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_valid_n2", {31'd0, bus.tx_valid}, 32'd0);
        @(posedge clk); #1;
        check("lat_valid_n3", {31'd0, bus.tx_valid}, 32'd1);
        check("single_data", bus.tx_data, 32'hDEADBEEF);
        check("single_last", {31'd0, bus.tx_last}, 32'd1);
        wait_idle(20, 1'b0, "single_timeout");
        exp_xfer++;
        check("single_busy_cycles", busy_cycles, 32'd4);
        check("single_xfer", xfer_cnt, exp_xfer);

        // backpressure with random ready
        for (int i = 0; i < 4; i++) ram[i] = 32'h100 + i;
        push_words(4, 32'h100);
        beats = 0;
        start_run(16'd4);
        wait_idle(400, 1'b1, "bp_timeout");
        exp_xfer++;
        check("bp_beats", beats, 32'd4);
        check("bp_xfer", xfer_cnt, exp_xfer);

        // full buffer
        for (int i = 0; i < 1024; i++) ram[i] = 32'hF000_0000 | i;
        push_words(1024, 32'hF000_0000);
        beats = 0;
        start_run(16'd1024);
        wait_idle(4000, 1'b0, "full_timeout");
        exp_xfer++;
        check("full_beats", beats, 32'd1024);
        check("full_last_addr", {22'd0, last_addr}, 32'h3FF);
        check("full_xfer", xfer_cnt, exp_xfer);
        ram[0] = 32'h1234_5678;
        push_words(1, 32'h1234_5678);
        start_run(16'd1);
        check("next_start_addr", {22'd0, dpram_rd_addr}, 32'd0);
        wait_idle(20, 1'b0, "next_timeout");
        exp_xfer++;

        // illegal lengths and err_clr priority
        busy_cycles = 0;
        start_run(16'd0);
        check("len0_err", {31'd0, err_len}, 32'd1);
        @(posedge clk); #1;
        check("len0_sticky", {31'd0, err_len}, 32'd1);
        pulse_err_clr();
        check("len0_clr", {31'd0, err_len}, 32'd0);
        start_run(16'd1025);
        check("len1025_err", {31'd0, err_len}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_busy_cycles", busy_cycles, 32'd0);
        @(posedge clk); #1;
        err_clr = 1'b1; dpram_run = 1'b1; dpram_len = 16'd0;
        @(posedge clk); #1;
        err_clr = 1'b0; dpram_run = 1'b0;
        check("clr_priority", {31'd0, err_len}, 32'd0);
        check("illegal_xfer", xfer_cnt, exp_xfer);

        // abort during the third beat of eight
        for (int i = 0; i < 8; i++) ram[i] = 32'h200 + i;
        exp_q.push_back({1'b0, 32'h200});
        exp_q.push_back({1'b0, 32'h201});
        beats = 0;
        start_run(16'd8);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (beats >= 2) break;
        end
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_valid) break;
            @(posedge clk); #1;
        end
        check("abort_third_beat", bus.tx_data, 32'h202);
        en = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, dpram_busy}, 32'd0);
        check("abort_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("abort_last", {31'd0, bus.tx_last}, 32'd0);
        check("abort_state", {29'd0, state_dbg}, 32'd0);
        check("abort_xfer", xfer_cnt, exp_xfer);
        check("abort_q_empty", exp_q.size(), 32'd0);
        en = 1'b1;
        bus.tx_ready = 1'b1;
        push_words(8, 32'h200);
        beats = 0;
        start_run(16'd8);
        wait_idle(100, 1'b0, "rerun_timeout");
        exp_xfer++;
        check("rerun_beats", beats, 32'd8);
        check("rerun_xfer", xfer_cnt, exp_xfer);

        // run pulses while busy are ignored
        for (int i = 0; i < 3; i++) ram[i] = 32'h300 + i;
        push_words(3, 32'h300);
        beats = 0;
        start_run(16'd3);
        dpram_run = 1'b1; dpram_len = 16'd10;
        @(posedge clk); #1;
        dpram_len = 16'd0;
        @(posedge clk); #1;
        dpram_run = 1'b0;
        wait_idle(100, 1'b0, "overlap_timeout");
        exp_xfer++;
        check("overlap_beats", beats, 32'd3);
        check("overlap_err", {31'd0, err_len}, 32'd0);
        check("overlap_xfer", xfer_cnt, exp_xfer);
        repeat (2) @(posedge clk);
        #1;
        check("overlap_xfer_stable", xfer_cnt, exp_xfer);

        // reset mid-transfer does not resume
        for (int i = 0; i < 4; i++) ram[i] = 32'h400 + i;
        push_words(4, 32'h400);
        start_run(16'd4);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("async_rst_busy", {31'd0, dpram_busy}, 32'd0);
        check("async_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, dpram_busy}, 32'd0);
        check("post_rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("post_rst_state", {29'd0, state_dbg}, 32'd0);
        check("post_rst_xfer", xfer_cnt, 32'd0);
        check("post_rst_addr", {22'd0, dpram_rd_addr}, 32'd0);

        check("extra_beats", extra, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
